// File: rtl/tftlcd_line_fetcher.sv
// Ping-pong line-buffer controller for the TFT LCD pixel path.
// One memory burst per visible line fills the write bank. The display bank is
// streamed to the timing generator while DE is high. Banks swap at end of line.
module tftlcd_line_fetcher #(
    parameter int                H_ACTIVE        = 800,
    parameter int                V_ACTIVE        = 480,
    parameter int                ADDR_W          = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = {ADDR_W{1'b0}},
    parameter logic [23:0]       UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_frame_start,
    input  logic              i_de,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [15:0]       o_rd_len,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [23:0]       i_rd_data,
    output logic [23:0]       o_pixel,
    output logic              o_underflow,
    output logic              o_busy
);

    localparam int PTR_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_END = LINE_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_r, state_n;
    logic [LINE_W-1:0]   fetch_line_r;
    logic                frame_seen_r;
    logic                any_fetched_r;
    logic [1:0]          bank_full_r, bank_full_n;
    logic                disp_bank_r;
    logic                wr_bank_r;
    logic [PTR_W-1:0]    word_cnt_r;
    logic                abort_r;
    logic                de_d_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [23:0]         pixel_r, pixel_n;
    logic                underflow_r;
    logic                rd_req_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                busy_r;
    logic [23:0]         bank0_mem [H_ACTIVE];
    logic [23:0]         bank1_mem [H_ACTIVE];

    logic                pending_s;
    logic                launch_s;
    logic                burst_last_s;
    logic                commit_s;
    logic                word_wr_s;
    logic                de_rise_s;
    logic                de_fall_s;
    logic [PTR_W-1:0]    ptr_s;
    logic [PTR_W-1:0]    ptr_next_s;
    logic [23:0]         disp_word_s;
    logic [ADDR_W-1:0]   fetch_addr_s;
    logic [1:0]          clr_mask_s;
    logic [1:0]          set_mask_s;

    assign pending_s    = frame_seen_r && (fetch_line_r < LINE_END);
    // A burst still lands in memory after a frame start; only its commit is suppressed.
    assign commit_s     = burst_last_s && !abort_r && !i_frame_start;
    assign word_wr_s    = (state_r == ST_DATA) && i_rd_valid && !abort_r;
    assign de_rise_s    = i_de && !de_d_r;
    assign de_fall_s    = de_d_r && !i_de;
    assign ptr_s        = de_rise_s ? {PTR_W{1'b0}} : rd_ptr_r;
    assign ptr_next_s   = (ptr_s == PTR_LAST) ? PTR_LAST : (ptr_s + PTR_W'(1));
    assign disp_word_s  = disp_bank_r ? bank1_mem[ptr_s] : bank0_mem[ptr_s];
    assign fetch_addr_s = BASE_ADDR + (ADDR_W'(fetch_line_r) * ADDR_W'(H_ACTIVE));
    // Clearing the leaving display bank and filling the other bank can coincide.
    assign clr_mask_s   = de_fall_s ? (2'b01 << disp_bank_r) : 2'b00;
    assign set_mask_s   = commit_s  ? (2'b01 << wr_bank_r)   : 2'b00;
    assign bank_full_n  = i_frame_start ? 2'b00 : ((bank_full_r & ~clr_mask_s) | set_mask_s);

    assign o_rd_req    = rd_req_r;
    assign o_rd_addr   = rd_addr_r;
    assign o_rd_len    = 16'(H_ACTIVE);
    assign o_pixel     = pixel_r;
    assign o_underflow = underflow_r;
    assign o_busy      = busy_r;

    // Fetch FSM next-state: one burst per line, launched only into an empty write bank.
    always_comb begin
        state_n      = state_r;
        launch_s     = 1'b0;
        burst_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_s && i_enable && !i_frame_start && !bank_full_r[wr_bank_r]) begin
                    state_n  = ST_REQ;
                    launch_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_rd_ack) begin
                    state_n = ST_DATA;
                end else if (i_frame_start) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_DATA: begin
                if (i_rd_valid && (word_cnt_r == PTR_LAST)) begin
                    state_n      = ST_IDLE;
                    burst_last_s = 1'b1;
                end else begin
                    state_n = ST_DATA;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Next display pixel: black when disabled or blanking, magenta when the bank is not ready.
    always_comb begin
        pixel_n = 24'h000000;
        if (!i_enable) begin
            pixel_n = 24'h000000;
        end else if (!i_de) begin
            pixel_n = 24'h000000;
        end else if (bank_full_r[disp_bank_r]) begin
            pixel_n = disp_word_s;
        end else begin
            pixel_n = UNDERFLOW_COLOR;
        end
    end

    // Line bank storage; contents are only meaningful once the bank is flagged full.
    always_ff @(posedge i_clk) begin
        if (word_wr_s) begin
            if (wr_bank_r) begin
                bank1_mem[word_cnt_r] <= i_rd_data;
            end else begin
                bank0_mem[word_cnt_r] <= i_rd_data;
            end
        end
    end

    // Control state, bank bookkeeping, display pointer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            fetch_line_r  <= {LINE_W{1'b0}};
            frame_seen_r  <= 1'b0;
            any_fetched_r <= 1'b0;
            bank_full_r   <= 2'b00;
            disp_bank_r   <= 1'b0;
            wr_bank_r     <= 1'b0;
            word_cnt_r    <= {PTR_W{1'b0}};
            abort_r       <= 1'b0;
            de_d_r        <= 1'b0;
            rd_ptr_r      <= {PTR_W{1'b0}};
            pixel_r       <= 24'h000000;
            underflow_r   <= 1'b0;
            rd_req_r      <= 1'b0;
            rd_addr_r     <= {ADDR_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            state_r     <= state_n;
            rd_req_r    <= (state_n == ST_REQ);
            busy_r      <= (state_n != ST_IDLE);
            bank_full_r <= bank_full_n;
            if (launch_s) begin
                rd_addr_r <= fetch_addr_s;
            end
            if (i_frame_start) begin
                fetch_line_r  <= {LINE_W{1'b0}};
                wr_bank_r     <= 1'b0;
                disp_bank_r   <= 1'b0;
                any_fetched_r <= 1'b0;
                frame_seen_r  <= 1'b1;
            end else begin
                if (commit_s) begin
                    fetch_line_r  <= fetch_line_r + LINE_W'(1);
                    wr_bank_r     <= ~wr_bank_r;
                    any_fetched_r <= 1'b1;
                end
                if (de_fall_s) begin
                    disp_bank_r <= ~disp_bank_r;
                end
            end
            // Abort covers the rest of a burst that was accepted before a frame start.
            if ((state_r == ST_REQ) && i_rd_ack) begin
                abort_r    <= i_frame_start;
                word_cnt_r <= {PTR_W{1'b0}};
            end else if (state_r == ST_DATA) begin
                abort_r <= burst_last_s ? 1'b0 : (abort_r | i_frame_start);
                if (i_rd_valid) begin
                    word_cnt_r <= burst_last_s ? {PTR_W{1'b0}} : (word_cnt_r + PTR_W'(1));
                end
            end
            de_d_r <= i_de;
            if (i_de) begin
                rd_ptr_r <= ptr_next_s;
            end
            pixel_r <= pixel_n;
            if (i_frame_start) begin
                underflow_r <= 1'b0;
            end else if (i_de && !bank_full_r[disp_bank_r] && any_fetched_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tftlcd_line_fetcher.md
Name: tftlcd_line_fetcher

Overview:
- Ping-pong line-buffer controller that feeds the TFT LCD timing generator's 24-bit pixel input.
- Prefetches each visible line from the memory read port into one of two line banks.
- Streams the current bank out while the timing generator's DE is high.
- Sequences one burst per line, swaps banks at end of line, and flags underflow when memory misses the deadline.

Parameters:
H_ACTIVE, 800, visible pixels per line; also the burst length in words
V_ACTIVE, 480, visible lines per frame
ADDR_W, 24, memory word-address width
BASE_ADDR, 0, word address of frame line 0; line n is at BASE_ADDR + n*H_ACTIVE
UNDERFLOW_COLOR, 24'hFF00FF, pixel driven while the display bank is not filled

Ports:
i_clk  in  1  pixel clock, same clock as the timing generator
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  block enable; when 0, no new requests are issued and the output is black
i_frame_start  in  1  one-cycle pulse at start of frame (VSYNC)
i_de  in  1  display enable from the timing generator
o_rd_req  out  1  burst request, held until acknowledged
o_rd_addr  out  ADDR_W  burst start word address
o_rd_len  out  16  burst length, constant H_ACTIVE
i_rd_ack  in  1  request accepted; sampled while o_rd_req=1
i_rd_valid  in  1  one read data word this cycle
i_rd_data  in  24  read data word {B,G,R}
o_pixel  out  24  pixel to the timing generator
o_underflow  out  1  sticky; cleared by i_frame_start or reset
o_busy  out  1  fetch FSM not in IDLE

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM to IDLE; both banks marked empty; line counters=0; display bank=0; write bank=0.
  - Outputs: o_rd_req=0, o_rd_addr=0, o_pixel=0, o_underflow=0, o_busy=0.
- Fetch FSM states and transitions:
  - IDLE -> REQ when a fetch is pending, i_enable=1, and the write bank is empty.
  - REQ: o_rd_req=1 and o_rd_addr=BASE_ADDR+fetch_line*H_ACTIVE, both stable. Go to DATA on the cycle i_rd_ack=1.
  - DATA: each i_rd_valid writes i_rd_data to write_bank[word_cnt], then word_cnt+1. On the H_ACTIVE-th word: mark the bank full, fetch_line+1, toggle the write bank, go to IDLE.
  - A word arriving in IDLE/REQ is ignored.
- Fetch pending means fetch_line < V_ACTIVE and at least one frame start has been seen. No fetch occurs after line V_ACTIVE-1 until the next frame start.
- Frame start:
  - Effects: fetch_line=0; display bank=0; write bank=0; both banks empty; o_underflow cleared.
  - If it occurs in REQ: the request is dropped (o_rd_req=0 next cycle) and re-issued for line 0.
  - If it occurs in DATA: the remaining words of the current burst are consumed and discarded (abort flag). The FSM then returns to IDLE and fetches line 0. Memory bursts are never cancelled.
- Display path:
  - rd_ptr=0 at i_de rising edge; rd_ptr increments each cycle i_de=1.
  - o_pixel registered, 1-cycle latency: o_pixel(t+1) = bank[display][rd_ptr(t)] when i_de(t)=1 and the display bank is full. Otherwise o_pixel = UNDERFLOW_COLOR.
  - When i_de=0: o_pixel=0.
  - When i_enable=0: o_pixel=0.
  - rd_ptr saturates at H_ACTIVE-1 if DE exceeds H_ACTIVE.
- Underflow: set o_underflow when i_de=1 and the display bank is empty, except when no line has yet been fetched this frame.
- End of line (i_de falling edge): mark the display bank empty and toggle the display bank. This frees the bank for the next fetch.
- Simultaneous events:
  - Frame start and DE fall in the same cycle: frame start wins.
  - Last word written into the bank about to become display, in the same cycle as the DE fall: the bank counts as full for the next line.
- Memory addressing: wrap-around at 2^ADDR_W is permitted.

Test Plan:
- Common setup: H_ACTIVE=8, V_ACTIVE=4, BASE_ADDR=0x100. The memory model acks 2 cycles after request and returns data = address.
- Reset then frame start -> o_rd_req with o_rd_addr=0x100, then 0x108 after the first burst. o_busy=1 during bursts. No third request before the first DE fall.
- Line display -> 8 DE cycles on line 0 give o_pixel=0x100..0x107, one cycle after each DE cycle. Line 1 gives 0x108..0x10F. o_underflow=0.
- Full frame -> exactly 4 requests (0x100, 0x108, 0x110, 0x118). No request after the 4th until the next frame start.
- Slow memory, line-1 data delayed past the DE rise -> o_pixel=0xFF00FF and o_underflow=1, held until the next frame start clears it.
- Frame start injected after 3 words of a burst -> the remaining 5 words are discarded. The next request is 0x100, and line 0 displays 0x100..0x107.
- i_rst_n low mid-burst -> all outputs 0 immediately (asynchronous). After release, no request until a frame start.
